// File: rtl/adc_channel_scheduler.sv
// Round-robin command/response sequencer for the MAX10 modular ADC Avalon-ST interface.
// One conversion is outstanding at a time; each matching response updates that slot's sample.
module adc_channel_scheduler #(
  parameter int NUM_CH   = 5,
  parameter int FIRST_CH = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 cmd_valid,
  output logic [4:0]           cmd_channel,
  output logic                 cmd_startofpacket,
  output logic                 cmd_endofpacket,
  input  logic                 cmd_ready,
  input  logic                 rsp_valid,
  input  logic [4:0]           rsp_channel,
  input  logic [11:0]          rsp_data,
  output logic [NUM_CH*12-1:0] sample_data,
  output logic [NUM_CH-1:0]    sample_new,
  output logic                 sweep_done,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TERM     = 8'(TIMEOUT - 1);
  localparam logic [2:0] LAST     = 3'(NUM_CH - 1);
  localparam logic [4:0] BASE_CH  = 5'(FIRST_CH);

  state_t              state;
  state_t              state_next;
  logic [2:0]          idx;
  logic [2:0]          idx_next;
  logic [7:0]          cnt;
  logic [4:0]          exp_ch;
  logic                accept;
  logic                hit;
  logic                expire;
  logic [NUM_CH-1:0]   new_mask;

  assign cmd_startofpacket = 1'b1;
  assign cmd_endofpacket   = 1'b1;
  assign exp_ch            = BASE_CH + {2'b00, idx};

  // A matching response on the terminal-count cycle counts as data, not a timeout.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    hit        = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          accept     = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = ISSUE;
        end
      end
      WAIT: begin
        hit    = rsp_valid && (rsp_channel == exp_ch);
        expire = !hit && (cnt == TERM);
        if (hit || expire) begin
          idx_next   = (idx == LAST) ? 3'd0 : idx + 3'd1;
          state_next = enable ? ISSUE : IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    new_mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      new_mask[k] = hit && (idx == 3'(k));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 3'd0;
      cnt         <= 8'd0;
      cmd_valid   <= 1'b0;
      cmd_channel <= BASE_CH;
      sample_data <= '0;
      sample_new  <= '0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (accept) begin
        cnt <= 8'd0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      // Command outputs are registered from the next state so a new command follows completion by one cycle.
      cmd_valid   <= (state_next == ISSUE);
      cmd_channel <= BASE_CH + {2'b00, idx_next};
      sample_new  <= new_mask;
      for (int k = 0; k < NUM_CH; k++) begin
        if (new_mask[k]) begin
          sample_data[12*k +: 12] <= rsp_data;
        end
      end
      sweep_done <= (hit || expire) && (idx == LAST);
      if (expire) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Self-checking bench: ADC responder, transaction-level reference model and per-cycle compare.
module tb_adc_channel_scheduler;

  localparam int NUM_CH   = 5;
  localparam int FIRST_CH = 1;
  localparam int TIMEOUT  = 20;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic enable  = 1'b0;
  logic err_clr = 1'b0;
  logic cmd_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic [4:0]  rsp_channel = 5'd0;
  logic [11:0] rsp_data    = 12'd0;
  logic cmd_valid, cmd_startofpacket, cmd_endofpacket, sweep_done, timeout_err;
  logic [4:0] cmd_channel;
  logic [NUM_CH*12-1:0] sample_data;
  logic [NUM_CH-1:0]    sample_new;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic chk_on = 1'b0;

  // responder configuration (changed only just after a rising edge)
  int rdy_prob = 100;
  int lat      = 3;
  logic lat_rand = 1'b0, noise_rand = 1'b0, mute_all = 1'b0, data_all = 1'b0;
  logic [4:0] mute_ch = 5'd0, noise_tgt = 5'd0;

  // responder state
  logic pend = 1'b0;
  int cd = 0;
  logic [4:0] pch = 5'd0;
  int acc_cnt = 0, acc_edge = 0, mute_edge = 0;
  int acc_q[$];

  // reference model state
  logic m_req = 1'b0, m_wait = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int m_age = 0, m_slot = 0;
  logic [11:0] m_samp [NUM_CH] = '{default: 12'd0};
  logic [NUM_CH-1:0] m_new = '0;

  int sn_cnt [NUM_CH] = '{default: 0};
  int sd_cnt = 0;

  adc_channel_scheduler #(.NUM_CH(NUM_CH), .FIRST_CH(FIRST_CH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel),
    .cmd_startofpacket(cmd_startofpacket), .cmd_endofpacket(cmd_endofpacket),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .sample_data(sample_data), .sample_new(sample_new), .sweep_done(sweep_done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] slot_of(input logic [NUM_CH*12-1:0] v, input int k);
    return v[12*k +: 12];
  endfunction

  // Reference model: one command outstanding, slots visited in order, timeout after TIMEOUT waiting cycles.
  always @(posedge sys_clk) begin : model
    logic req, wt, fin, tmo, dn;
    int age, slot;
    logic [NUM_CH-1:0] nw;
    req = m_req; wt = m_wait; age = m_age; slot = m_slot;
    nw = '0; dn = 1'b0; fin = 1'b0; tmo = 1'b0;
    if (reset) begin
      m_req <= 1'b0; m_wait <= 1'b0; m_age <= 0; m_slot <= 0;
      for (int k = 0; k < NUM_CH; k++) m_samp[k] <= 12'd0;
      m_new <= '0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      if (wt) begin
        if (rsp_valid && rsp_channel == 5'(FIRST_CH + slot)) begin
          m_samp[slot] <= rsp_data;
          nw[slot] = 1'b1;
          fin = 1'b1;
        end else if (age + 1 == TIMEOUT) begin
          tmo = 1'b1;
          fin = 1'b1;
        end else begin
          age = age + 1;
        end
        if (fin) begin
          dn   = (slot == NUM_CH - 1);
          slot = (slot + 1) % NUM_CH;
          wt   = 1'b0;
          req  = enable;
        end
      end else if (req) begin
        if (cmd_ready) begin
          req = 1'b0; wt = 1'b1; age = 0;
        end
      end else begin
        req = enable;
      end
      m_req <= req; m_wait <= wt; m_age <= age; m_slot <= slot;
      m_new <= nw; m_done <= dn;
      m_err <= tmo ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge sys_clk) begin
    if (chk_on) begin
      logic [NUM_CH*12-1:0] exp_data;
      for (int k = 0; k < NUM_CH; k++) exp_data[12*k +: 12] = m_samp[k];
      check("cmd_valid", 64'(cmd_valid), 64'(m_req));
      check("cmd_channel", 64'(cmd_channel), 64'(5'(FIRST_CH + m_slot)));
      check("sop_eop", 64'({cmd_startofpacket, cmd_endofpacket}), 64'(2'b11));
      check("sample_data", 64'(sample_data), 64'(exp_data));
      check("sample_new", 64'(sample_new), 64'(m_new));
      check("sample_new_onehot", 64'($onehot0(sample_new)), 64'(1));
      check("sweep_done", 64'(sweep_done), 64'(m_done));
      check("timeout_err", 64'(timeout_err), 64'(m_err));
      for (int k = 0; k < NUM_CH; k++) sn_cnt[k] += int'(sample_new[k]);
      sd_cnt += int'(sweep_done);
    end
  end

  // ADC responder: accepts commands, answers after a latency, optionally injects noise.
  always @(negedge sys_clk) begin
    rsp_valid   = 1'b0;
    rsp_channel = 5'd0;
    rsp_data    = 12'd0;
    if (pend) begin
      cd = cd - 1;
      if (cd == 0) begin
        pend        = 1'b0;
        rsp_valid   = 1'b1;
        rsp_channel = pch;
        rsp_data    = data_all ? 12'h555 : ((pch == noise_tgt) ? 12'h123 : 12'h0A0 + 12'(pch));
      end else if (cd == 1 && pch == noise_tgt) begin
        rsp_valid   = 1'b1;
        rsp_channel = 5'd5;
        rsp_data    = 12'hFFF;
      end
    end
    if (!rsp_valid && noise_rand && $urandom_range(0, 7) == 0) begin
      rsp_valid   = 1'b1;
      rsp_channel = 5'($urandom_range(0, 7));
      rsp_data    = 12'($urandom);
    end
    cmd_ready = ($urandom_range(0, 99) < rdy_prob);
    if (cmd_valid === 1'b1 && cmd_ready) begin
      acc_cnt++;
      acc_edge = cyc + 1;
      acc_q.push_back(int'(cmd_channel));
      if (mute_all || cmd_channel == mute_ch) begin
        pend = 1'b0;
        mute_edge = cyc + 1;
      end else begin
        pend = 1'b1;
        pch  = cmd_channel;
        cd   = lat_rand ? $urandom_range(1, 24) : lat;
      end
    end
  end

  initial begin
    int n, snap, idx3, sn2, k;
    logic [11:0] s4;
    @(posedge sys_clk); #1;
    chk_on = 1'b1;
    check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    check("rst_cmd_channel", 64'(cmd_channel), 64'(1));
    check("rst_sample_data", 64'(sample_data), 64'(0));
    @(negedge sys_clk); @(negedge sys_clk);
    reset = 1'b0; enable = 1'b1;

    // Sweep with a 3-cycle responder
    for (n = 0; n < 200 && acc_q.size() < 6; n++) begin @(posedge sys_clk); #1; end
    check("t1_six_cmds", 64'(acc_q.size() >= 6), 64'(1));
    for (int i = 0; i < 6 && i < acc_q.size(); i++) check("t1_cmd_order", 64'(acc_q[i]), 64'((i % 5) + 1));
    check("t1_samples", 64'(sample_data), 64'h0A5_0A4_0A3_0A2_0A1);
    for (int i = 0; i < NUM_CH; i++) check("t1_new_count", 64'(sn_cnt[i]), 64'(1));
    check("t1_sweep_count", 64'(sd_cnt), 64'(1));

    // Command held while cmd_ready is low, enable dropped mid-wait
    @(negedge sys_clk); reset = 1'b1; enable = 1'b0;
    @(posedge sys_clk); #1; rdy_prob = 0;
    @(negedge sys_clk); reset = 1'b0; enable = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", 64'(cmd_valid), 64'(1));
      check("t2_hold_channel", 64'(cmd_channel), 64'(1));
      @(negedge sys_clk); if (i == 1) enable = 1'b0;
      @(posedge sys_clk); #1; if (i == 8) rdy_prob = 100;
    end
    repeat (12) begin @(posedge sys_clk); #1; end
    check("t2_idle_valid", 64'(cmd_valid), 64'(0));
    check("t2_idle_channel", 64'(cmd_channel), 64'(2));
    check("t2_slot0", 64'(slot_of(sample_data, 0)), 64'h0A1);
    sn2 = sn_cnt[2];
    mute_ch = 5'd3;
    @(negedge sys_clk); enable = 1'b1;
    @(posedge sys_clk); #1;
    check("t2_resume_channel", 64'(cmd_channel), 64'(2));

    // Channel 3 never answers
    for (n = 0; n < 200 && timeout_err !== 1'b1; n++) begin @(posedge sys_clk); #1; end
    check("t3_timeout_seen", 64'(timeout_err), 64'(1));
    check("t3_timeout_delay", 64'(cyc - mute_edge), 64'(20));
    check("t3_slot2_kept", 64'(slot_of(sample_data, 2)), 64'h000);
    mute_ch = 5'd0; noise_tgt = 5'd2;
    repeat (10) begin @(posedge sys_clk); #1; end
    check("t3_no_new2", 64'(sn_cnt[2]), 64'(sn2));
    idx3 = -1;
    for (int i = 0; i + 1 < acc_q.size(); i++) if (acc_q[i] == 3) idx3 = i;
    check("t3_next_channel", 64'((idx3 >= 0) ? acc_q[idx3 + 1] : -1), 64'(4));

    // Mismatched response while waiting on channel 2
    s4 = slot_of(sample_data, 4);
    for (n = 0; n < 200 && sample_new[1] !== 1'b1; n++) begin @(posedge sys_clk); #1; end
    check("t4_slot1", 64'(slot_of(sample_data, 1)), 64'h123);
    check("t4_slot4", 64'(slot_of(sample_data, 4)), 64'(s4));
    check("t4_slot4_lit", 64'(s4), 64'h0A5);
    noise_tgt = 5'd0;

    // err_clr alone, terminal-count response, set beats clear
    @(negedge sys_clk); err_clr = 1'b1;
    @(negedge sys_clk); err_clr = 1'b0;
    @(posedge sys_clk); #1;
    check("t5_clear", 64'(timeout_err), 64'(0));
    lat = 20; snap = acc_cnt;
    for (n = 0; n < 60 && acc_cnt == snap; n++) begin @(posedge sys_clk); #1; end
    for (n = 0; n < 60 && sample_new === '0; n++) begin @(posedge sys_clk); #1; end
    k = 0;
    for (int i = 0; i < NUM_CH; i++) if (sample_new[i]) k = i;
    check("t5_tc_new", 64'(sample_new != '0), 64'(1));
    check("t5_tc_data", 64'(slot_of(sample_data, k)), 64'(12'h0A0 + 12'(FIRST_CH + k)));
    check("t5_tc_no_err", 64'(timeout_err), 64'(0));
    lat = 3; mute_all = 1'b1;
    for (n = 0; n < 80 && timeout_err !== 1'b1; n++) begin @(posedge sys_clk); #1; end
    check("t5_first_timeout", 64'(timeout_err), 64'(1));
    snap = acc_cnt;
    for (n = 0; n < 20 && acc_cnt == snap; n++) begin @(posedge sys_clk); #1; end
    for (n = 0; n < 40 && cyc < acc_edge + 19; n++) begin @(posedge sys_clk); #1; end
    @(negedge sys_clk); err_clr = 1'b1;
    @(posedge sys_clk); #1;
    check("t5_set_wins", 64'(timeout_err), 64'(1));
    check("t5_set_wins_cycle", 64'(cyc - acc_edge), 64'(20));
    mute_all = 1'b0;
    @(negedge sys_clk); err_clr = 1'b0;

    // Reset while a response is pending
    data_all = 1'b1; lat = 5; snap = acc_cnt;
    for (n = 0; n < 60 && acc_cnt == snap; n++) begin @(posedge sys_clk); #1; end
    @(negedge sys_clk);
    @(negedge sys_clk); reset = 1'b1; enable = 1'b0;
    @(posedge sys_clk); #1;
    check("t6_rst_data", 64'(sample_data), 64'(0));
    check("t6_rst_valid", 64'(cmd_valid), 64'(0));
    check("t6_rst_channel", 64'(cmd_channel), 64'(1));
    check("t6_rst_err", 64'(timeout_err), 64'(0));
    check("t6_rst_pulses", 64'({sample_new, sweep_done}), 64'(0));
    @(negedge sys_clk); reset = 1'b0;
    repeat (8) begin @(posedge sys_clk); #1; end
    check("t6_late_rsp_ignored", 64'(sample_data), 64'(0));
    data_all = 1'b0;

    // Randomized traffic against the model
    lat_rand = 1'b1; noise_rand = 1'b1; rdy_prob = 70;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      enable  = ($urandom_range(0, 7) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 299) == 0);
    end
    @(negedge sys_clk); reset = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
